// File: rtl/capture_ctrl.sv
// Logic-analyser capture controller: fills a circular RAM around a trigger event,
// then dumps the buffer oldest-first, one byte per transmitter handshake.
module capture_ctrl #(
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wrt_smpl,
    input  logic            run,
    input  logic [LOG2-1:0] trig_pos,
    input  logic            triggered,
    input  logic            dump,
    input  logic [7:0]      rdata,
    input  logic            resp_sent,
    output logic            we,
    output logic [LOG2-1:0] waddr,
    output logic [LOG2-1:0] raddr,
    output logic            armed,
    output logic            capture_done,
    output logic            send_resp,
    output logic [7:0]      resp
);

    localparam int CW = LOG2 + 1;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] FILL      = 3'd1;
    localparam logic [2:0] ARMED     = 3'd2;
    localparam logic [2:0] POST      = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;
    localparam logic [2:0] DUMP_RD   = 3'd5;
    localparam logic [2:0] DUMP_TX   = 3'd6;
    localparam logic [2:0] DUMP_WAIT = 3'd7;

    localparam logic [LOG2-1:0] LAST_ADDR = LOG2'(ENTRIES - 1);
    localparam logic [CW-1:0]   ENTRIES_C = CW'(ENTRIES);

    logic [2:0]      state;
    logic [LOG2-1:0] tpos_q;
    logic [CW-1:0]   smpl_cnt;
    logic [CW-1:0]   post_cnt;
    logic [CW-1:0]   byte_cnt;

    logic [LOG2-1:0] tpos_clamped;
    logic [LOG2-1:0] waddr_nxt;
    logic [LOG2-1:0] raddr_nxt;
    logic [CW-1:0]   fill_target;
    logic            capturing;
    logic            dumping;

    always_comb begin
        tpos_clamped = (trig_pos > LAST_ADDR) ? LAST_ADDR : trig_pos;
        // Pre-trigger depth leaves exactly trig_pos slots for post-trigger samples.
        fill_target  = ENTRIES_C - {1'b0, tpos_q};
        waddr_nxt    = (waddr == LAST_ADDR) ? '0 : waddr + 1'b1;
        raddr_nxt    = (raddr == LAST_ADDR) ? '0 : raddr + 1'b1;
        capturing    = (state == FILL) || (state == ARMED) || (state == POST);
        dumping      = (state == DUMP_RD) || (state == DUMP_TX) || (state == DUMP_WAIT);
    end

    assign we = wrt_smpl & capturing;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            tpos_q       <= '0;
            smpl_cnt     <= '0;
            post_cnt     <= '0;
            byte_cnt     <= '0;
            waddr        <= '0;
            raddr        <= '0;
            armed        <= 1'b0;
            capture_done <= 1'b0;
            send_resp    <= 1'b0;
            resp         <= 8'h00;
        end else begin
            send_resp <= 1'b0;
            if (run && !dumping) begin
                state        <= FILL;
                tpos_q       <= tpos_clamped;
                smpl_cnt     <= '0;
                post_cnt     <= '0;
                waddr        <= '0;
                armed        <= 1'b0;
                capture_done <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    FILL: begin
                        if (wrt_smpl) begin
                            waddr    <= waddr_nxt;
                            smpl_cnt <= smpl_cnt + 1'b1;
                            if (smpl_cnt + 1'b1 == fill_target) begin
                                state <= ARMED;
                                armed <= 1'b1;
                            end
                        end
                    end
                    ARMED: begin
                        // A write coinciding with the trigger still belongs to the pre-trigger window.
                        if (wrt_smpl)
                            waddr <= waddr_nxt;
                        if (triggered) begin
                            post_cnt <= '0;
                            if (tpos_q == '0) begin
                                state        <= DONE;
                                capture_done <= 1'b1;
                                armed        <= 1'b0;
                            end else begin
                                state <= POST;
                            end
                        end
                    end
                    POST: begin
                        if (wrt_smpl) begin
                            waddr    <= waddr_nxt;
                            post_cnt <= post_cnt + 1'b1;
                            if (post_cnt + 1'b1 == {1'b0, tpos_q}) begin
                                state        <= DONE;
                                capture_done <= 1'b1;
                                armed        <= 1'b0;
                            end
                        end
                    end
                    DONE: begin
                        // waddr now points at the oldest sample in the ring.
                        if (dump) begin
                            raddr    <= waddr;
                            byte_cnt <= '0;
                            state    <= DUMP_RD;
                        end
                    end
                    DUMP_RD: state <= DUMP_TX;
                    DUMP_TX: begin
                        resp      <= rdata;
                        send_resp <= 1'b1;
                        state     <= DUMP_WAIT;
                    end
                    DUMP_WAIT: begin
                        if (resp_sent) begin
                            raddr    <= raddr_nxt;
                            byte_cnt <= byte_cnt + 1'b1;
                            state    <= (byte_cnt + 1'b1 == ENTRIES_C) ? IDLE : DUMP_RD;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl: table of capture shapes plus hand-written
// corner sequences; dumped bytes are checked against a queue of written samples.
module tb_capture_ctrl;

    localparam int ENTRIES = 8;
    localparam int LOG2    = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            wrt_smpl;
    logic            run;
    logic [LOG2-1:0] trig_pos;
    logic            triggered;
    logic            dump;
    logic [7:0]      rdata;
    logic            resp_sent;
    logic            we;
    logic [LOG2-1:0] waddr;
    logic [LOG2-1:0] raddr;
    logic            armed;
    logic            capture_done;
    logic            send_resp;
    logic [7:0]      resp;

    capture_ctrl #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
        .clk(clk), .rst(rst), .wrt_smpl(wrt_smpl), .run(run), .trig_pos(trig_pos),
        .triggered(triggered), .dump(dump), .rdata(rdata), .resp_sent(resp_sent),
        .we(we), .waddr(waddr), .raddr(raddr), .armed(armed),
        .capture_done(capture_done), .send_resp(send_resp), .resp(resp)
    );

    always #5 clk = ~clk;

    // Synchronous RAM model with one-cycle read latency
    logic [7:0] mem [ENTRIES];
    logic [7:0] wdata;
    always @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

    int         ncmp = 0;
    int         nerr = 0;
    int         nsend = 0;
    bit         outstanding = 0;
    bit         tx_en = 0;
    int         samp = 0;
    logic [7:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every send_resp pops one expected byte; no second send before resp_sent
    always @(negedge clk) begin
        if (send_resp) begin
            nsend++;
            if (outstanding) begin
                ncmp++; nerr++;
                $display("FAIL send_twice: send_resp again without resp_sent");
            end
            outstanding = 1;
            if (exp_q.size() == 0) begin
                ncmp++; nerr++;
                $display("FAIL unexpected_send: resp=%0d while no byte expected", resp);
            end else begin
                chk("dump_byte", resp, exp_q.pop_front());
            end
        end
        if (resp_sent) outstanding = 0;
    end

    // Transmitter model: acknowledges each byte ten clocks after the request
    initial begin
        resp_sent = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_en && send_resp) begin
                repeat (10) @(posedge clk);
                #1 resp_sent = 1'b1;
                @(posedge clk);
                #1 resp_sent = 1'b0;
            end
        end
    end

    task automatic start_run(input int tp);
        trig_pos = LOG2'(tp);
        exp_q.delete();
        samp = 0;
        run = 1'b1;
        step();
        run = 1'b0;
    endtask

    task automatic write1();
        wrt_smpl = 1'b1;
        wdata = 8'(samp % ENTRIES);
        exp_q.push_back(wdata);
        samp++;
        step();
        wrt_smpl = 1'b0;
    endtask

    task automatic fill(output int n);
        n = 0;
        for (int i = 0; i < 2 * ENTRIES && !armed; i++) begin
            write1();
            n++;
        end
    endtask

    task automatic post(output int n);
        triggered = 1'b1;
        step();
        triggered = 1'b0;
        n = 0;
        for (int i = 0; i < 2 * ENTRIES && !capture_done; i++) begin
            write1();
            n++;
        end
    endtask

    task automatic trim_expect();
        while (exp_q.size() > ENTRIES) void'(exp_q.pop_front());
    endtask

    task automatic do_dump(input string name);
        int start;
        trim_expect();
        start = nsend;
        tx_en = 1;
        dump = 1'b1;
        step();
        dump = 1'b0;
        for (int i = 0; i < ENTRIES * 16 && ((nsend - start) < ENTRIES || outstanding); i++) step();
        repeat (20) step();
        chk({name, "_byte_count"}, nsend - start, ENTRIES);
        chk({name, "_left_expected"}, exp_q.size(), 0);
        tx_en = 0;
    endtask

    typedef struct {
        int tp;
        int extra;
        int exp_pre;
        int exp_wa_armed;
        int exp_wa_done;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int n;
        int start;

        tbl[0] = '{3, 2, 5, 5, 2};
        tbl[1] = '{0, 1, 8, 0, 1};
        tbl[2] = '{7, 0, 1, 1, 0};
        tbl[3] = '{5, 4, 3, 3, 4};
        tbl[4] = '{1, 3, 7, 7, 3};

        rst = 1'b1; wrt_smpl = 1'b0; run = 1'b0; trig_pos = '0;
        triggered = 1'b0; dump = 1'b0; wdata = '0;
        step(); step();
        wrt_smpl = 1'b1;
        #1;
        chk("rst_we", we, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_raddr", raddr, 0);
        chk("rst_armed", armed, 0);
        chk("rst_capture_done", capture_done, 0);
        chk("rst_send_resp", send_resp, 0);
        chk("rst_resp", resp, 0);
        wrt_smpl = 1'b0;
        rst = 1'b0;
        step();

        // Idle: writes are not enabled before a run
        wrt_smpl = 1'b1;
        #1;
        chk("idle_we", we, 0);
        wrt_smpl = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            start_run(tbl[i].tp);
            wrt_smpl = 1'b1;
            #1;
            chk("fill_we", we, 1);
            wrt_smpl = 1'b0;
            fill(n);
            chk("pre_count", n, tbl[i].exp_pre);
            chk("waddr_armed", waddr, tbl[i].exp_wa_armed);
            chk("armed_set", armed, 1);
            repeat (tbl[i].extra) write1();
            post(n);
            chk("post_count", n, tbl[i].tp);
            chk("capture_done", capture_done, 1);
            chk("armed_cleared", armed, 0);
            chk("waddr_done", waddr, tbl[i].exp_wa_done);
            wrt_smpl = 1'b1;
            #1;
            chk("done_we", we, 0);
            wrt_smpl = 1'b0;
            do_dump("dump");
            chk("done_held_after_dump", capture_done, 1);
            start = nsend;
            dump = 1'b1;
            step();
            dump = 1'b0;
            repeat (20) step();
            chk("dump_in_idle_ignored", nsend - start, 0);
        end

        // Trigger held during fill must not shorten the pre-trigger window
        start_run(3);
        triggered = 1'b1;
        fill(n);
        triggered = 1'b0;
        chk("trig_in_fill_pre", n, 5);
        chk("trig_in_fill_done", capture_done, 0);

        // Restart from POST
        triggered = 1'b1;
        step();
        triggered = 1'b0;
        write1();
        chk("post_not_done", capture_done, 0);
        start_run(3);
        chk("restart_waddr", waddr, 0);
        chk("restart_armed", armed, 0);
        chk("restart_done", capture_done, 0);

        // Dump during FILL is ignored
        start = nsend;
        tx_en = 1;
        dump = 1'b1;
        step();
        dump = 1'b0;
        repeat (20) step();
        chk("dump_in_fill_ignored", nsend - start, 0);
        tx_en = 0;
        fill(n);
        chk("restart_pre_count", n, 5);

        // Reset while waiting for the transmitter
        post(n);
        chk("abort_post_count", n, 3);
        trim_expect();
        start = nsend;
        tx_en = 1;
        dump = 1'b1;
        step();
        dump = 1'b0;
        for (int i = 0; i < 10 && nsend == start; i++) step();
        chk("abort_first_send", nsend - start, 1);
        step(); step();
        #2;
        rst = 1'b1;
        tx_en = 0;
        wrt_smpl = 1'b1;
        #1;
        chk("abort_we", we, 0);
        chk("abort_waddr", waddr, 0);
        chk("abort_raddr", raddr, 0);
        chk("abort_armed", armed, 0);
        chk("abort_done", capture_done, 0);
        chk("abort_send_resp", send_resp, 0);
        chk("abort_resp", resp, 0);
        wrt_smpl = 1'b0;
        exp_q.delete();
        outstanding = 0;
        step();
        rst = 1'b0;
        repeat (40) step();
        chk("abort_no_more_sends", nsend - start, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1);
    end

endmodule
